// File: rtl/jtframe_joydb15.sv
// SNAC DB15 user-port joystick reader: two chained 74HC165s, 16 bits per player.
// Define JTFRAME_JOYDB15_FILTER_EN to publish a word only after two identical scans.
module jtframe_joydb15 #(
    parameter int CLK_DIV     = 16,
    parameter int SCAN_PERIOD = 48000,
    parameter int NBITS       = 32
) (
    input  logic        RESET,
    input  logic        clk_sys,
    input  logic [1:0]  mode,
    input  logic        JOY_DATA,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    output logic [15:0] joy1,
    output logic [15:0] joy2,
    output logic        joy_valid
);

    localparam int PW = $clog2(SCAN_PERIOD);
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(NBITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_CLKLO,
        ST_CLKHI,
        ST_LATCH
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_sync;
    logic             w_din;
    logic [PW-1:0]    r_per;
    logic             w_tick;
    logic             w_on;
    logic             w_start;
    logic [DW-1:0]    r_div;
    logic             w_div_last;
    logic [BW-1:0]    r_bit;
    logic [BW-1:0]    w_bit_inc;
    logic [NBITS-1:0] r_shreg;
    logic             w_shift;
    logic             w_latch;
    logic             w_upd;
    logic             r_joy_clk;
    logic             r_joy_load;
    logic             w_clk_nxt;
    logic             w_load_nxt;
    logic [15:0]      r_joy1;
    logic [15:0]      r_joy2;
    logic             r_valid;

    assign w_din      = r_sync[1];
    assign w_on       = mode != 2'd0;
    assign w_tick     = r_per == PW'(SCAN_PERIOD - 1);
    assign w_start    = (r_state == ST_IDLE) && w_tick && w_on;
    assign w_div_last = r_div == DW'(CLK_DIV - 1);
    assign w_bit_inc  = r_bit + 1'b1;

    assign JOY_CLK   = r_joy_clk;
    assign JOY_LOAD  = r_joy_load;
    assign joy1      = r_joy1;
    assign joy2      = r_joy2;
    assign joy_valid = r_valid;

    // Idle-high sync keeps a floating line reading as "no buttons"
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], JOY_DATA};
        end
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            r_per <= '0;
        end else if (!w_on || w_tick || w_start) begin
            r_per <= '0;
        end else begin
            r_per <= r_per + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        w_latch     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (w_div_last) w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (w_div_last) w_state_nxt = ST_CLKLO;
            end
            ST_CLKLO: begin
                if (w_div_last) begin
                    w_shift     = 1'b1;
                    w_state_nxt = ST_CLKHI;
                end
            end
            ST_CLKHI: begin
                if (w_div_last) begin
                    if (w_bit_inc == BW'(NBITS)) w_state_nxt = ST_LATCH;
                    else w_state_nxt = ST_CLKLO;
                end
            end
            ST_LATCH: begin
                w_latch     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (!w_on) begin
            w_state_nxt = ST_IDLE;
            w_shift     = 1'b0;
            w_latch     = 1'b0;
        end
    end

    // Strobes are registered from the next state so they stay glitch-free
    always_comb begin
        w_clk_nxt  = 1'b1;
        w_load_nxt = 1'b1;
        if (w_state_nxt == ST_LOAD || w_state_nxt == ST_SETTLE ||
            w_state_nxt == ST_CLKLO) begin
            w_clk_nxt = 1'b0;
        end
        if (w_state_nxt == ST_LOAD) begin
            w_load_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            r_joy_clk  <= 1'b1;
            r_joy_load <= 1'b1;
        end else begin
            r_joy_clk  <= w_clk_nxt;
            r_joy_load <= w_load_nxt;
        end
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            r_div <= '0;
        end else if (w_state_nxt != r_state || r_state == ST_IDLE) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            r_bit <= '0;
        end else if (r_state == ST_SETTLE && w_div_last) begin
            r_bit <= '0;
        end else if (r_state == ST_CLKHI && w_div_last) begin
            r_bit <= w_bit_inc;
        end
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            r_shreg <= '1;
        end else if (w_shift) begin
            r_shreg <= {r_shreg[NBITS-2:0], w_din};
        end
    end

`ifdef JTFRAME_JOYDB15_FILTER_EN
    logic [NBITS-1:0] r_cand;

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            r_cand <= '0;
        end else if (!w_on) begin
            r_cand <= '0;
        end else if (w_latch) begin
            r_cand <= r_shreg;
        end
    end

    assign w_upd = w_latch && (r_shreg == r_cand);
`else
    assign w_upd = w_latch;
`endif

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            r_joy1  <= '0;
            r_joy2  <= '0;
            r_valid <= 1'b0;
        end else if (!w_on) begin
            r_joy1  <= '0;
            r_joy2  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_upd;
            if (w_upd) begin
                r_joy1 <= ~r_shreg[NBITS-1 -: 16];
                r_joy2 <= (mode == 2'd1) ? 16'h0000 : ~r_shreg[15:0];
            end
        end
    end

endmodule

// File: tb/tb_jtframe_joydb15.sv
// Bench for jtframe_joydb15: 74HC165 adapter model, queue scoreboard and
// randomized scans; honours JTFRAME_JOYDB15_FILTER_EN when defined.
module tb_jtframe_joydb15;

    localparam int CLK_DIV     = 4;
    localparam int SCAN_PERIOD = 400;
    localparam int NBITS       = 32;
    localparam int SCAN_LEN    = 66 * CLK_DIV + 1;
`ifdef JTFRAME_JOYDB15_FILTER_EN
    localparam int REP = 2;
`else
    localparam int REP = 1;
`endif

    logic        RESET;
    logic        clk_sys = 1'b0;
    logic [1:0]  mode;
    logic        JOY_DATA;
    logic        JOY_CLK;
    logic        JOY_LOAD;
    logic [15:0] joy1;
    logic [15:0] joy2;
    logic        joy_valid;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_sys = ~clk_sys;

    jtframe_joydb15 #(
        .CLK_DIV    (CLK_DIV),
        .SCAN_PERIOD(SCAN_PERIOD),
        .NBITS      (NBITS)
    ) dut (
        .RESET    (RESET),
        .clk_sys  (clk_sys),
        .mode     (mode),
        .JOY_DATA (JOY_DATA),
        .JOY_CLK  (JOY_CLK),
        .JOY_LOAD (JOY_LOAD),
        .joy1     (joy1),
        .joy2     (joy2),
        .joy_valid(joy_valid)
    );

    // Adapter: parallel load while LOAD low, shift on JOY_CLK rise, pull-up in
    logic [31:0] adp_word = 32'hFFFF_FFFF;
    logic [31:0] adp_sr   = 32'hFFFF_FFFF;
    logic        adp_prev = 1'b1;

    always @(negedge clk_sys) begin
        if (!JOY_LOAD) adp_sr <= adp_word;
        else if (JOY_CLK && !adp_prev) adp_sr <= {adp_sr[30:0], 1'b1};
        adp_prev <= JOY_CLK;
    end

    assign JOY_DATA = adp_sr[31];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: word in, expected {joy1,joy2} out
    logic [31:0] exp_q[$];
    logic [31:0] mdl_cand = '0;

    task automatic model_scan(input logic [31:0] w, input logic [1:0] m);
        logic [31:0] e;
        e[31:16] = ~w[31:16];
        e[15:0]  = (m == 2'd1) ? 16'h0000 : ~w[15:0];
`ifdef JTFRAME_JOYDB15_FILTER_EN
        if (w == mdl_cand) exp_q.push_back(e);
        mdl_cand = w;
`else
        exp_q.push_back(e);
`endif
    endtask

    // Monitor
    int          cyc        = 0;
    int          last_valid = -1;
    int          rises      = 0;
    int          load_lo    = 0;
    logic        mon_pclk   = 1'b1;
    logic        mon_pload  = 1'b1;
    logic [31:0] mon_e;

    initial forever begin
        @(negedge clk_sys);
        cyc++;
        if (JOY_LOAD === 1'b0 && mon_pload) begin
            rises   = 0;
            load_lo = 0;
        end
        if (JOY_LOAD === 1'b0) load_lo++;
        if (JOY_CLK === 1'b1 && !mon_pclk) rises++;
        mon_pclk  = JOY_CLK;
        mon_pload = JOY_LOAD;
        if (RESET || mode == 2'd0) begin
            last_valid = -1;
            rises      = 0;
            load_lo    = 0;
        end else if (joy_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: joy1=%h joy2=%h want none",
                         joy1, joy2);
            end else begin
                mon_e = exp_q.pop_front();
                check("joy1", 32'(joy1), 32'(mon_e[31:16]));
                check("joy2", 32'(joy2), 32'(mon_e[15:0]));
            end
            check("clk_rises", rises, NBITS);
            check("load_low", load_lo, CLK_DIV);
`ifndef JTFRAME_JOYDB15_FILTER_EN
            if (last_valid >= 0) check("valid_gap", cyc - last_valid, SCAN_PERIOD);
`endif
            last_valid = cyc;
        end
    end

    task automatic wait_load(output int t);
        t = 0;
        while (JOY_LOAD !== 1'b0 && t <= 2 * SCAN_PERIOD) begin
            @(negedge clk_sys);
            t++;
        end
        if (JOY_LOAD !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL load_timeout: got none want JOY_LOAD low");
        end
    endtask

    task automatic finish_scan(input logic [31:0] w, input logic [1:0] m1,
                               input int flip);
        model_scan(w, m1);
        repeat (flip) @(negedge clk_sys);
        mode = m1;
        repeat (SCAN_LEN + 4 - flip) @(negedge clk_sys);
    endtask

    task automatic run_scan(input logic [31:0] w, input logic [1:0] m0,
                            input logic [1:0] m1, input int flip);
        int t;
        adp_word = w;
        mode     = m0;
        wait_load(t);
        finish_scan(w, m1, flip);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_clk"}, 32'(JOY_CLK), 32'd1);
        check({tag, "_load"}, 32'(JOY_LOAD), 32'd1);
        check({tag, "_joy1"}, 32'(joy1), 32'd0);
        check({tag, "_joy2"}, 32'(joy2), 32'd0);
        check({tag, "_valid"}, 32'(joy_valid), 32'd0);
    endtask

    initial begin
        int          t;
        int          r;
        logic        p;
        logic [31:0] w;
        logic [31:0] pw;
        logic [1:0]  m0;
        logic [1:0]  m1;

        RESET = 1'b1;
        mode  = 2'd0;
        repeat (3) @(negedge clk_sys);
        check_idle_zero("reset");
        RESET = 1'b0;

        r = 0;
        repeat (SCAN_PERIOD + 20) begin
            @(negedge clk_sys);
            if (JOY_LOAD === 1'b0) r++;
        end
        check("off_no_scan", r, 0);

        for (int i = 0; i < REP; i++) run_scan(32'hFFFE_7FFF, 2'd2, 2'd2, 10);
        for (int i = 0; i < REP; i++) run_scan(32'hFFFE_7FFF, 2'd1, 2'd1, 10);
        for (int i = 0; i < REP; i++) run_scan(32'hFFFF_FFFF, 2'd2, 2'd2, 10);
        for (int i = 0; i < REP; i++) run_scan(32'h0000_0000, 2'd2, 2'd2, 10);
        w = $urandom;
        for (int i = 0; i < REP; i++) run_scan(w, 2'd1, 2'd2, 100);
        for (int i = 0; i < REP; i++) run_scan(w, 2'd2, 2'd1, 200);

        // Abort after the 10th shift clock
        adp_word = $urandom;
        mode     = 2'd2;
        wait_load(t);
        r = 0;
        p = JOY_CLK;
        t = 0;
        while (r < 10 && t < 2000) begin
            @(negedge clk_sys);
            t++;
            if (JOY_CLK && !p) r++;
            p = JOY_CLK;
        end
        check("abort_rises", r, 10);
        mode     = 2'd0;
        mdl_cand = '0;
        @(negedge clk_sys);
        check_idle_zero("abort");
        repeat (20) @(negedge clk_sys);
        w        = $urandom;
        adp_word = w;
        mode     = 2'd2;
        wait_load(t);
        check("restart_gap", t, SCAN_PERIOD);
        finish_scan(w, 2'd2, 10);
        for (int i = 1; i < REP; i++) run_scan(w, 2'd2, 2'd2, 10);

        // Reset in the middle of shifting
        adp_word = $urandom;
        wait_load(t);
        repeat (40) @(negedge clk_sys);
        RESET = 1'b1;
        #1;
        check_idle_zero("midreset");
        mdl_cand = '0;
        @(negedge clk_sys);
        RESET = 1'b0;
        w = $urandom;
        for (int i = 0; i < REP; i++) run_scan(w, 2'd2, 2'd2, 10);

        pw = w;
        for (int i = 0; i < 30; i++) begin
            w  = ($urandom_range(0, 1) == 0 && REP == 2) ? pw : $urandom;
            m0 = 2'($urandom_range(1, 3));
            m1 = ($urandom_range(0, 1) == 0) ? m0 : 2'($urandom_range(1, 3));
            run_scan(w, m0, m1, $urandom_range(1, 66 * CLK_DIV - 2));
            pw = w;
        end

`ifdef JTFRAME_JOYDB15_FILTER_EN
        mode = 2'd0;
        mdl_cand = '0;
        repeat (5) @(negedge clk_sys);
        for (int i = 0; i < 4; i++) begin
            run_scan(32'hFFFF_FFFE, 2'd2, 2'd2, 10);
            run_scan(32'hFFFF_FFFF, 2'd2, 2'd2, 10);
        end
        check("filt_hold_joy1", 32'(joy1), 32'd0);
        check("filt_hold_joy2", 32'(joy2), 32'd0);
        run_scan(32'hFFFF_FFFE, 2'd2, 2'd2, 10);
        run_scan(32'hFFFF_FFFE, 2'd2, 2'd2, 10);
        check("filt_joy2", 32'(joy2), 32'd1);
`endif

        repeat (20) @(negedge clk_sys);
        check("missing_valid", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jtframe_joydb15.md
Name: jtframe_joydb15

Overview:
- Serial reader for the SNAC DB15 joystick adapter on the MiSTer user port. The adapter is two chained 74HC165 registers, 16 bits per player.
- The block generates the JOY_LOAD and JOY_CLK strobes, shifts in JOY_DATA and delivers debounced, active-high joystick words.
- It sits upstream of jtframe_mister's joystick merge logic.
- Runs in the clk_sys domain.

Parameters:
- CLK_DIV, 16: clk_sys cycles per JOY_CLK half-period. Must be ≥4.
- SCAN_PERIOD, 48000: clk_sys cycles between scan starts, measured start-to-start. Must be >66*CLK_DIV+2.
- NBITS, 32: total bits shifted per scan. Player 1 occupies the first 16 bits shifted.

Ports:
- RESET  in  1  asynchronous, active-high reset
- clk_sys  in  1  system clock
- mode  in  2  OSD setting: 0 = off, 1 = one player, 2 or 3 = two players
- JOY_DATA  in  1  serial data from the adapter, asynchronous, active-low buttons
- JOY_CLK  out  1  shift clock to the adapter; idles high
- JOY_LOAD  out  1  parallel load, active-low; idles high
- joy1  out  16  player 1 buttons, active-high
- joy2  out  16  player 2 buttons, active-high
- joy_valid  out  1  one-cycle pulse when joy1/joy2 update

Behaviour:
- Reset values: JOY_CLK=1, JOY_LOAD=1, joy1=0, joy2=0, joy_valid=0; shift register all ones; FSM in IDLE; period counter 0.
- JOY_DATA passes through a 2-flop synchronizer, reset to 1. Call its output din.
- Period counter:
  - Free-running 0..SCAN_PERIOD-1 while mode≠0.
  - Generates a scan tick at terminal count.
  - Held at 0 when mode=0.
  - Restarts at 0 on every scan start, so scans never overlap.
- FSM states: IDLE, LOAD, SETTLE, CLKLO, CLKHI, LATCH.
- IDLE:
  - JOY_CLK=1, JOY_LOAD=1.
  - On tick with mode≠0 → LOAD; the first tick after mode leaves 0 happens SCAN_PERIOD cycles later.
- LOAD: JOY_LOAD=0, JOY_CLK=0 for CLK_DIV cycles → SETTLE.
- SETTLE: JOY_LOAD=1, JOY_CLK=0 for CLK_DIV cycles → CLKLO, bit counter=0.
- CLKLO:
  - JOY_CLK=0 for CLK_DIV cycles.
  - On the last cycle, shreg <= {shreg[NBITS-2:0], din}.
  - Then → CLKHI.
- CLKHI:
  - JOY_CLK=1 for CLK_DIV cycles.
  - Bit counter increments on exit.
  - If the counter reaches NBITS → LATCH, else → CLKLO.
- LATCH:
  - One cycle: joy1 <= ~shreg[31:16], joy2 <= ~shreg[15:0], joy_valid=1.
  - Next state IDLE.
  - When mode=1, joy2 <= 0 regardless of data.
- Scan length: 66*CLK_DIV+1 cycles from LOAD entry to LATCH, i.e. 1057 cycles at defaults.
- Bit order: the first bit sampled lands in joy1[15]; the last lands in joy2[0].
- Mode changes:
  - mode → 0 at any time, including mid-scan: next cycle the FSM is IDLE, strobes are at idle levels, joy1=joy2=0, no joy_valid.
  - Change between 1 and 2 mid-scan: the scan completes; the mode value present in the LATCH cycle governs joy2.
- Disconnected adapter: the pull-up makes din read all ones, so outputs are 0. No special handling.
- Reset asserted mid-scan: all state returns to reset values immediately (asynchronous reset).

Optional Feature:
- Macro: JTFRAME_JOYDB15_FILTER_EN.
- Defined:
  - LATCH compares the new 32-bit word with the word captured in the previous scan.
  - joy1/joy2 and joy_valid update only when both words are identical; otherwise the outputs hold and the new word is stored as the candidate.
  - The candidate resets to 0 and is cleared when mode=0.
  - First update therefore needs two matching scans.
- Undefined: every scan updates the outputs, as described in Behaviour.

Test Plan:
- Reset, then mode=2, CLK_DIV=4, SCAN_PERIOD=400, adapter model holding 0xFFFE_7FFF → joy1=0x0001, joy2=0x8000. joy_valid pulses once per 400 cycles. JOY_LOAD low for 4 cycles per scan; exactly 32 JOY_CLK rising edges per scan.
- mode=1 with the same data → joy1=0x0001, joy2=0x0000.
- JOY_DATA stuck at 1 → joy1=joy2=0 and joy_valid still pulses. JOY_DATA stuck at 0 → joy1=joy2=0xFFFF.
- mode forced to 0 after the 10th JOY_CLK rising edge → next cycle JOY_CLK=1, JOY_LOAD=1, outputs 0, no joy_valid. With mode back to 2, the next scan starts 400 cycles later.
- RESET pulsed mid-shift → all outputs at reset values. The first subsequent scan yields the correct word.
- With the FILTER macro: alternate scans of 0xFFFF_FFFE and 0xFFFF_FFFF → outputs hold at 0 and no joy_valid. Two consecutive 0xFFFF_FFFE scans → joy2=0x0001 with a single joy_valid.
